mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Memory-access (MA) stage of the RV32IM 5-stage pipeline; sits between the EX/MA pipeline register and the MA/WB pipeline register. Drives the data-memory handshake for loads and stores, generating byte enables, store-data lane steering and load sign/zero extension. Holds the pipeline via MA_STALL while memory is busy, and suppresses misaligned, illegal or timed-out accesses with a fault flag. Produces the MA_MEM_OUT and gated MA_REG_EN values the MA/WB register captures.

## Interface
- TIMEOUT, 255: max cycles in ACCESS before abort; must be ≥1, counter width $clog2(TIMEOUT+1)
- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-high
- MA_ALU_OUT  in  32  effective address / ALU result
- MA_STORE_DATA  in  32  rs2 value for stores
- MA_FUNCT3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- MA_MEM_READ  in  1  load in stage
- MA_MEM_WRITE  in  1  store in stage
- MA_REG_EN_IN  in  1  register-write enable from EX/MA
- DMEM_RDATA  in  32  memory read word (word-aligned)
- DMEM_BUSYWAIT  in  1  memory busy; low = request complete this cycle
- DMEM_READ  out  1  read request
- DMEM_WRITE  out  1  write request
- DMEM_ADDR  out  32  {MA_ALU_OUT[31:2], 2'b00}
- DMEM_WDATA  out  32  lane-steered store data
- DMEM_BYTE_EN  out  4  byte-lane enables
- MA_MEM_OUT  out  32  extended load result to MA/WB
- MA_REG_EN  out  1  MA_REG_EN_IN gated by fault
- MA_STALL  out  1  freeze PC, IF/ID, ID/EX, EX/MA; MA/WB loads bubble
- MA_MEM_FAULT  out  1  access suppressed/aborted this cycle

## Operation
- Reset RESET asynchronous, active-high; clock CLK. Reset: state IDLE, counter 0, load register 0; all outputs 0 (DMEM_ADDR/WDATA/BYTE_EN 0).
- States: IDLE, ACCESS, DONE (shared package encoding).
- access = MA_MEM_READ | MA_MEM_WRITE. fault_pre (IDLE only): both READ and WRITE high; funct3 011/110/111, or store funct3 ∉ {000,001,010}; H with addr[0]=1; W with addr[1:0]≠0.
- IDLE, no access: pass-through, MA_STALL=0, MA_MEM_OUT=0, MA_REG_EN=MA_REG_EN_IN.
- IDLE, access & fault_pre: no request, MA_STALL=0, MA_MEM_FAULT=1, MA_REG_EN=0, MA_MEM_OUT=0; stay IDLE.
- IDLE, access & legal: MA_STALL=1, requests still 0; → ACCESS, counter cleared.
- ACCESS: DMEM_READ/WRITE held per op, MA_STALL=1. DMEM_BUSYWAIT=0 → capture extended DMEM_RDATA (loads; 0 for stores), → DONE. Otherwise counter++; counter reaching TIMEOUT → drop request, → DONE with fault latched.
- DONE: requests 0, MA_STALL=0, MA_MEM_OUT=captured value, MA_MEM_FAULT=latched fault, MA_REG_EN=MA_REG_EN_IN & ~fault; → IDLE.
- Stores: SB BYTE_EN=0001<<a[1:0], WDATA={4{d[7:0]}}; SH 0011<<a[1:0], WDATA={2{d[15:0]}}; SW 1111, d. Loads: BYTE_EN same masks, lane selected by a[1:0], sign (B/H) or zero (BU/HU) extended to 32.
- Input changes while ACCESS/DONE ignored (operands latched on IDLE→ACCESS edge).
- Reset mid-ACCESS: requests drop asynchronously, no capture, state IDLE.

## Timing
- Legal access: 1 IDLE + N ACCESS (N≥1, = cycles until BUSYWAIT low) + 1 DONE; MA_STALL high IDLE through last ACCESS cycle.
- MA/WB captures result on the DONE→IDLE edge; new instruction enters on same edge.
- Non-memory and faulted instructions: zero added cycles.
- Timeout: DONE follows the ACCESS cycle where counter hits TIMEOUT; total stall TIMEOUT+1 cycles.
- All outputs except registered load value are combinational from state + latched operands.

## Structure
- Package mem_pkg: funct3 constants (F3_B/H/W/BU/HU), state typedef/encoding, byte-enable mask constants.
- Sub-module load_extend (combinational): rdata, addr[1:0], funct3 → 32-bit extended result; reused for capture path.
- FSM, timeout counter, operand latches, store steering in top module.

## Test plan
- LW addr 0x100, RDATA 0xDEADBEEF, BUSYWAIT low first ACCESS cycle → STALL 2 cycles, DONE MEM_OUT 0xDEADBEEF, REG_EN 1.
- LB addr 0x103, RDATA 0x80FF_FFFF, BUSYWAIT 3 cycles → BYTE_EN 1000, MEM_OUT 0xFFFFFF80, STALL 4 cycles; LBU same → 0x00000080.
- SH addr 0x202, data 0x1234ABCD → DMEM_WRITE, BYTE_EN 1100, WDATA 0xABCDABCD, REG_EN 0 in DONE.
- LW addr 0x101 → no request, STALL 0, FAULT 1, REG_EN 0, MEM_OUT 0 same cycle.
- TIMEOUT=4, BUSYWAIT stuck high → request dropped after 4 ACCESS cycles, DONE FAULT 1, REG_EN 0.
- RESET pulse mid-ACCESS → DMEM_READ/STALL 0 immediately, state IDLE, next LW completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: funct3 codes, FSM encoding,
// byte-lane masks and small decode helpers.
package mem_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned BEW  = 4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [BEW-1:0] BE_BYTE = 4'b0001;
    localparam logic [BEW-1:0] BE_HALF = 4'b0011;
    localparam logic [BEW-1:0] BE_WORD = 4'b1111;

    // Byte-lane enables for a given access size and byte offset
    function automatic logic [BEW-1:0] byte_en_mask(input logic [2:0] funct3,
                                                    input logic [1:0] offs);
        case (funct3)
            F3_B, F3_BU: return BE_BYTE << offs;
            F3_H, F3_HU: return BE_HALF << offs;
            F3_W:        return BE_WORD;
            default:     return '0;
        endcase
    endfunction

    // Accesses that must be suppressed before any request is issued
    function automatic logic access_illegal(input logic       rd,
                                            input logic       wr,
                                            input logic [2:0] funct3,
                                            input logic [1:0] offs);
        logic bad;
        bad = rd & wr;
        case (funct3)
            F3_B:        bad = bad;
            F3_BU:       bad = bad | wr;
            F3_H:        bad = bad | offs[0];
            F3_HU:       bad = bad | wr | offs[0];
            F3_W:        bad = bad | (offs != 2'b00);
            default:     bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Replicate store data across all lanes; byte enables pick the live ones
    function automatic logic [XLEN-1:0] store_steer(input logic [2:0]      funct3,
                                                    input logic [XLEN-1:0] d);
        case (funct3)
            F3_B:    return {4{d[7:0]}};
            F3_H:    return {2{d[15:0]}};
            F3_W:    return d;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory handshake bundle between the MA stage (master) and memory (slave).
interface mem_access_stage_if;

    logic        DMEM_READ;
    logic        DMEM_WRITE;
    logic [31:0] DMEM_ADDR;
    logic [31:0] DMEM_WDATA;
    logic [3:0]  DMEM_BYTE_EN;
    logic [31:0] DMEM_RDATA;
    logic        DMEM_BUSYWAIT;

    modport master (
        output DMEM_READ,
        output DMEM_WRITE,
        output DMEM_ADDR,
        output DMEM_WDATA,
        output DMEM_BYTE_EN,
        input  DMEM_RDATA,
        input  DMEM_BUSYWAIT
    );

    modport slave (
        input  DMEM_READ,
        input  DMEM_WRITE,
        input  DMEM_ADDR,
        input  DMEM_WDATA,
        input  DMEM_BYTE_EN,
        output DMEM_RDATA,
        output DMEM_BUSYWAIT
    );

endinterface

// File: rtl/mem_access_stage_load_extend.sv
// Combinational load lane select plus sign/zero extension of a word-aligned read.
module load_extend
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{addr, 3'b000} +: 8];
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   result = {24'h000000, byte_sel};
            F3_H:    result = {{16{half_sel[15]}}, half_sel};
            F3_HU:   result = {16'h0000, half_sel};
            F3_W:    result = rdata;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// RV32IM memory-access stage: data-memory handshake, store steering, load
// extension, pipeline stall and fault suppression.
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [31:0]        MA_ALU_OUT,
    input  logic [31:0]        MA_STORE_DATA,
    input  logic [2:0]         MA_FUNCT3,
    input  logic               MA_MEM_READ,
    input  logic               MA_MEM_WRITE,
    input  logic               MA_REG_EN_IN,
    mem_access_stage_if.master dmem,
    output logic [31:0]        MA_MEM_OUT,
    output logic               MA_REG_EN,
    output logic               MA_STALL,
    output logic               MA_MEM_FAULT
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   count;
    logic [31:0]     addr_q;
    logic [31:0]     sdata_q;
    logic [2:0]      f3_q;
    logic            rd_q;
    logic            wr_q;
    logic            reg_en_q;
    logic            fault_q;
    logic [31:0]     load_q;

    logic            access;
    logic            fault_pre;
    logic            timeout_hit;
    logic [31:0]     load_ext;

    assign access      = MA_MEM_READ | MA_MEM_WRITE;
    assign fault_pre   = access_illegal(MA_MEM_READ, MA_MEM_WRITE, MA_FUNCT3, MA_ALU_OUT[1:0]);
    assign timeout_hit = dmem.DMEM_BUSYWAIT && (count == CW'(TIMEOUT - 1));

    load_extend u_load_extend (
        .rdata  (dmem.DMEM_RDATA),
        .addr   (addr_q[1:0]),
        .funct3 (f3_q),
        .result (load_ext)
    );

    // State register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Operand latches, timeout counter, load capture and fault latch
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            count    <= '0;
            addr_q   <= '0;
            sdata_q  <= '0;
            f3_q     <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            reg_en_q <= 1'b0;
            fault_q  <= 1'b0;
            load_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (access && !fault_pre) begin
                        count    <= '0;
                        addr_q   <= MA_ALU_OUT;
                        sdata_q  <= MA_STORE_DATA;
                        f3_q     <= MA_FUNCT3;
                        rd_q     <= MA_MEM_READ;
                        wr_q     <= MA_MEM_WRITE;
                        reg_en_q <= MA_REG_EN_IN;
                        fault_q  <= 1'b0;
                    end
                end
                ST_ACCESS: begin
                    if (!dmem.DMEM_BUSYWAIT) begin
                        load_q <= rd_q ? load_ext : 32'h0;
                    end else if (timeout_hit) begin
                        fault_q <= 1'b1;
                        load_q  <= 32'h0;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Next state and all stage outputs
    always_comb begin
        state_next        = state;
        dmem.DMEM_READ    = 1'b0;
        dmem.DMEM_WRITE   = 1'b0;
        dmem.DMEM_ADDR    = '0;
        dmem.DMEM_WDATA   = '0;
        dmem.DMEM_BYTE_EN = '0;
        MA_MEM_OUT        = '0;
        MA_REG_EN         = 1'b0;
        MA_STALL          = 1'b0;
        MA_MEM_FAULT      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (!access) begin
                    MA_REG_EN = MA_REG_EN_IN;
                end else if (fault_pre) begin
                    MA_MEM_FAULT = 1'b1;
                end else begin
                    MA_STALL   = 1'b1;
                    state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                MA_STALL          = 1'b1;
                dmem.DMEM_READ    = rd_q;
                dmem.DMEM_WRITE   = wr_q;
                dmem.DMEM_ADDR    = {addr_q[31:2], 2'b00};
                dmem.DMEM_BYTE_EN = byte_en_mask(f3_q, addr_q[1:0]);
                dmem.DMEM_WDATA   = wr_q ? store_steer(f3_q, sdata_q) : 32'h0;
                if (!dmem.DMEM_BUSYWAIT || timeout_hit) state_next = ST_DONE;
            end
            ST_DONE: begin
                MA_MEM_OUT   = load_q;
                MA_MEM_FAULT = fault_q;
                MA_REG_EN    = reg_en_q & ~fault_q;
                state_next   = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage with a latency-programmable memory responder.
module tb_mem_access_stage;
    import mem_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] MA_ALU_OUT;
    logic [31:0] MA_STORE_DATA;
    logic [2:0]  MA_FUNCT3;
    logic        MA_MEM_READ;
    logic        MA_MEM_WRITE;
    logic        MA_REG_EN_IN;
    logic [31:0] MA_MEM_OUT;
    logic        MA_REG_EN;
    logic        MA_STALL;
    logic        MA_MEM_FAULT;

    int asserts  = 0;
    int failures = 0;

    int          lat;
    logic [31:0] rdata_v;
    logic [7:0]  acc_cnt;

    int          r_stall;
    logic [31:0] r_out;
    logic        r_reg_en;
    logic        r_fault;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [31:0] r_addr;
    logic        r_rd;
    logic        r_wr;
    logic        r_req_done;

    always #5 CLK = ~CLK;

    mem_access_stage_if dif ();

    mem_access_stage #(.TIMEOUT(4)) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .MA_ALU_OUT    (MA_ALU_OUT),
        .MA_STORE_DATA (MA_STORE_DATA),
        .MA_FUNCT3     (MA_FUNCT3),
        .MA_MEM_READ   (MA_MEM_READ),
        .MA_MEM_WRITE  (MA_MEM_WRITE),
        .MA_REG_EN_IN  (MA_REG_EN_IN),
        .dmem          (dif),
        .MA_MEM_OUT    (MA_MEM_OUT),
        .MA_REG_EN     (MA_REG_EN),
        .MA_STALL      (MA_STALL),
        .MA_MEM_FAULT  (MA_MEM_FAULT)
    );

    // Memory answers in the lat-th request cycle; lat==0 never answers
    always @(posedge CLK or posedge RESET) begin
        if (RESET) acc_cnt <= 8'd0;
        else if (dif.DMEM_READ || dif.DMEM_WRITE) acc_cnt <= acc_cnt + 8'd1;
        else acc_cnt <= 8'd0;
    end
    assign dif.DMEM_BUSYWAIT = (lat == 0) || (int'(acc_cnt) != lat - 1);
    assign dif.DMEM_RDATA    = rdata_v;

    task automatic run_access(input logic [31:0] addr, input logic [31:0] data,
                              input logic [2:0] f3, input logic rd, input logic wr,
                              input logic reg_en_in, input int latency, input logic [31:0] rdata);
        @(negedge CLK);
        MA_ALU_OUT    = addr;
        MA_STORE_DATA = data;
        MA_FUNCT3     = f3;
        MA_MEM_READ   = rd;
        MA_MEM_WRITE  = wr;
        MA_REG_EN_IN  = reg_en_in;
        lat           = latency;
        rdata_v       = rdata;
        #1;
        r_stall = 0; r_rd = 1'b0; r_wr = 1'b0; r_be = '0; r_wdata = '0; r_addr = '0;
        for (int i = 0; i < 300 && MA_STALL; i++) begin
            r_stall++;
            if (dif.DMEM_READ || dif.DMEM_WRITE) begin
                r_rd    = r_rd | dif.DMEM_READ;
                r_wr    = r_wr | dif.DMEM_WRITE;
                r_be    = dif.DMEM_BYTE_EN;
                r_wdata = dif.DMEM_WDATA;
                r_addr  = dif.DMEM_ADDR;
            end
            @(negedge CLK);
            #1;
        end
        r_out      = MA_MEM_OUT;
        r_reg_en   = MA_REG_EN;
        r_fault    = MA_MEM_FAULT;
        r_req_done = dif.DMEM_READ | dif.DMEM_WRITE;
        @(negedge CLK);
        MA_MEM_READ  = 1'b0;
        MA_MEM_WRITE = 1'b0;
        MA_REG_EN_IN = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        MA_ALU_OUT = '0; MA_STORE_DATA = '0; MA_FUNCT3 = '0;
        MA_MEM_READ = 1'b0; MA_MEM_WRITE = 1'b0; MA_REG_EN_IN = 1'b0;
        lat = 1; rdata_v = '0;
        repeat (2) @(negedge CLK);
        #1;
        asserts++; if ({dif.DMEM_READ, dif.DMEM_WRITE, MA_STALL, MA_MEM_FAULT, MA_REG_EN} !== 5'b0) begin failures++; $display("FAIL reset_ctrl: got %b expected 00000", {dif.DMEM_READ, dif.DMEM_WRITE, MA_STALL, MA_MEM_FAULT, MA_REG_EN}); end
        asserts++; if ({dif.DMEM_ADDR, dif.DMEM_WDATA, dif.DMEM_BYTE_EN} !== 68'h0) begin failures++; $display("FAIL reset_bus: addr %h wdata %h be %b expected zeros", dif.DMEM_ADDR, dif.DMEM_WDATA, dif.DMEM_BYTE_EN); end
        asserts++; if (MA_MEM_OUT !== 32'h0) begin failures++; $display("FAIL reset_memout: got %h expected 0", MA_MEM_OUT); end
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic test_lw();
        run_access(32'h100, 32'h0, F3_W, 1'b1, 1'b0, 1'b1, 1, 32'hDEADBEEF);
        asserts++; if (r_stall !== 2) begin failures++; $display("FAIL lw_stall: got %0d expected 2", r_stall); end
        asserts++; if (r_out !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_out: got %h expected deadbeef", r_out); end
        asserts++; if ({r_reg_en, r_fault, r_rd, r_wr} !== 4'b1010) begin failures++; $display("FAIL lw_flags: got %b expected 1010", {r_reg_en, r_fault, r_rd, r_wr}); end
        asserts++; if ({r_be, r_addr} !== {4'b1111, 32'h100}) begin failures++; $display("FAIL lw_bus: be %b addr %h expected 1111 00000100", r_be, r_addr); end
    endtask

    task automatic test_byte_loads();
        run_access(32'h103, 32'h0, F3_B, 1'b1, 1'b0, 1'b1, 3, 32'h80FFFFFF);
        asserts++; if (r_stall !== 4) begin failures++; $display("FAIL lb_stall: got %0d expected 4", r_stall); end
        asserts++; if ({r_be, r_addr} !== {4'b1000, 32'h100}) begin failures++; $display("FAIL lb_bus: be %b addr %h expected 1000 00000100", r_be, r_addr); end
        asserts++; if (r_out !== 32'hFFFFFF80) begin failures++; $display("FAIL lb_out: got %h expected ffffff80", r_out); end
        run_access(32'h103, 32'h0, F3_BU, 1'b1, 1'b0, 1'b1, 3, 32'h80FFFFFF);
        asserts++; if (r_out !== 32'h00000080) begin failures++; $display("FAIL lbu_out: got %h expected 00000080", r_out); end
        asserts++; if (r_reg_en !== 1'b1) begin failures++; $display("FAIL lbu_regen: got %b expected 1", r_reg_en); end
    endtask

    task automatic test_half_loads();
        run_access(32'h102, 32'h0, F3_H, 1'b1, 1'b0, 1'b1, 2, 32'h80011234);
        asserts++; if (r_out !== 32'hFFFF8001) begin failures++; $display("FAIL lh_out: got %h expected ffff8001", r_out); end
        asserts++; if (r_be !== 4'b1100) begin failures++; $display("FAIL lh_be: got %b expected 1100", r_be); end
        run_access(32'h100, 32'h0, F3_HU, 1'b1, 1'b0, 1'b1, 1, 32'h80011234);
        asserts++; if (r_out !== 32'h00001234) begin failures++; $display("FAIL lhu_out: got %h expected 00001234", r_out); end
    endtask

    task automatic test_stores();
        run_access(32'h202, 32'h1234ABCD, F3_H, 1'b0, 1'b1, 1'b0, 1, 32'hFFFFFFFF);
        asserts++; if ({r_rd, r_wr} !== 2'b01) begin failures++; $display("FAIL sh_req: got %b expected 01", {r_rd, r_wr}); end
        asserts++; if ({r_be, r_addr} !== {4'b1100, 32'h200}) begin failures++; $display("FAIL sh_bus: be %b addr %h expected 1100 00000200", r_be, r_addr); end
        asserts++; if (r_wdata !== 32'hABCDABCD) begin failures++; $display("FAIL sh_wdata: got %h expected abcdabcd", r_wdata); end
        asserts++; if ({r_reg_en, r_fault, r_out} !== 34'h0) begin failures++; $display("FAIL sh_done: regen %b fault %b out %h expected 0 0 0", r_reg_en, r_fault, r_out); end
        run_access(32'h301, 32'h000000A5, F3_B, 1'b0, 1'b1, 1'b0, 2, 32'h0);
        asserts++; if ({r_be, r_wdata} !== {4'b0010, 32'hA5A5A5A5}) begin failures++; $display("FAIL sb_bus: be %b wdata %h expected 0010 a5a5a5a5", r_be, r_wdata); end
        asserts++; if (r_stall !== 3) begin failures++; $display("FAIL sb_stall: got %0d expected 3", r_stall); end
        run_access(32'h404, 32'hCAFEF00D, F3_W, 1'b0, 1'b1, 1'b0, 1, 32'h0);
        asserts++; if ({r_be, r_wdata} !== {4'b1111, 32'hCAFEF00D}) begin failures++; $display("FAIL sw_bus: be %b wdata %h expected 1111 cafef00d", r_be, r_wdata); end
    endtask

    task automatic test_faults();
        run_access(32'h101, 32'h0, F3_W, 1'b1, 1'b0, 1'b1, 1, 32'hDEADBEEF);
        asserts++; if (r_stall !== 0) begin failures++; $display("FAIL lw_mis_stall: got %0d expected 0", r_stall); end
        asserts++; if ({r_fault, r_reg_en, r_rd, r_req_done} !== 4'b1000) begin failures++; $display("FAIL lw_mis_flags: got %b expected 1000", {r_fault, r_reg_en, r_rd, r_req_done}); end
        asserts++; if (r_out !== 32'h0) begin failures++; $display("FAIL lw_mis_out: got %h expected 0", r_out); end
        run_access(32'h103, 32'h0, F3_HU, 1'b1, 1'b0, 1'b1, 1, 32'h0);
        asserts++; if ({r_stall != 0, r_fault} !== 2'b01) begin failures++; $display("FAIL lhu_mis: stall %0d fault %b expected 0 1", r_stall, r_fault); end
        run_access(32'h100, 32'h0, 3'b011, 1'b1, 1'b0, 1'b1, 1, 32'h0);
        asserts++; if ({r_stall != 0, r_fault} !== 2'b01) begin failures++; $display("FAIL f3_011: stall %0d fault %b expected 0 1", r_stall, r_fault); end
        run_access(32'h100, 32'h55, F3_BU, 1'b0, 1'b1, 1'b0, 1, 32'h0);
        asserts++; if ({r_stall != 0, r_fault, r_wr} !== 3'b010) begin failures++; $display("FAIL store_bu: stall %0d fault %b wr %b expected 0 1 0", r_stall, r_fault, r_wr); end
        run_access(32'h100, 32'h0, F3_W, 1'b1, 1'b1, 1'b1, 1, 32'h0);
        asserts++; if ({r_stall != 0, r_fault, r_reg_en} !== 3'b010) begin failures++; $display("FAIL rd_and_wr: stall %0d fault %b regen %b expected 0 1 0", r_stall, r_fault, r_reg_en); end
    endtask

    task automatic test_passthrough();
        run_access(32'h101, 32'h0, 3'b111, 1'b0, 1'b0, 1'b1, 1, 32'hFFFFFFFF);
        asserts++; if ({r_stall != 0, r_fault, r_reg_en} !== 3'b001) begin failures++; $display("FAIL pass_regen1: stall %0d fault %b regen %b expected 0 0 1", r_stall, r_fault, r_reg_en); end
        asserts++; if (r_out !== 32'h0) begin failures++; $display("FAIL pass_out: got %h expected 0", r_out); end
        run_access(32'h0, 32'h0, F3_W, 1'b0, 1'b0, 1'b0, 1, 32'h0);
        asserts++; if (r_reg_en !== 1'b0) begin failures++; $display("FAIL pass_regen0: got %b expected 0", r_reg_en); end
    endtask

    task automatic test_timeout();
        run_access(32'h100, 32'h0, F3_W, 1'b1, 1'b0, 1'b1, 0, 32'h12345678);
        asserts++; if (r_stall !== 5) begin failures++; $display("FAIL to_stall: got %0d expected 5", r_stall); end
        asserts++; if ({r_fault, r_reg_en, r_req_done} !== 3'b100) begin failures++; $display("FAIL to_done: got %b expected 100", {r_fault, r_reg_en, r_req_done}); end
        asserts++; if (r_out !== 32'h0) begin failures++; $display("FAIL to_out: got %h expected 0", r_out); end
    endtask

    task automatic test_reset_mid_access();
        @(negedge CLK);
        MA_ALU_OUT = 32'h100; MA_FUNCT3 = F3_W; MA_MEM_READ = 1'b1; MA_REG_EN_IN = 1'b1;
        lat = 0; rdata_v = 32'h0BADF00D;
        repeat (2) @(negedge CLK);
        #1;
        asserts++; if ({dif.DMEM_READ, MA_STALL} !== 2'b11) begin failures++; $display("FAIL rst_pre: read/stall %b expected 11", {dif.DMEM_READ, MA_STALL}); end
        MA_MEM_READ = 1'b0; MA_REG_EN_IN = 1'b0;
        RESET = 1'b1;
        #1;
        asserts++; if ({dif.DMEM_READ, MA_STALL, MA_MEM_FAULT} !== 3'b000) begin failures++; $display("FAIL rst_mid: read/stall/fault %b expected 000", {dif.DMEM_READ, MA_STALL, MA_MEM_FAULT}); end
        @(negedge CLK);
        RESET = 1'b0;
        run_access(32'h108, 32'h0, F3_W, 1'b1, 1'b0, 1'b1, 2, 32'h0BADF00D);
        asserts++; if ({r_stall == 3, r_out == 32'h0BADF00D, r_reg_en, r_fault} !== 4'b1110) begin failures++; $display("FAIL rst_after: stall %0d out %h regen %b fault %b expected 3 0badf00d 1 0", r_stall, r_out, r_reg_en, r_fault); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_byte_loads();
        test_half_loads();
        test_stores();
        test_faults();
        test_passthrough();
        test_timeout();
        test_reset_mid_access();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
